// File: rtl/alu.sv
// alu -- 32-bit integer ALU for the ARM32 datapath.
// Operations: ADD, SUB, AND, OR, MUL, DIV, NOT, XOR selected by ALU_op.
// The result and the N/Z/D/V status word are registered, giving one cycle of latency.
// The status word is laid out as [31]=N [30]=Z [29]=D (divide by zero) [28]=V, with [27:0] always zero.
// Optional build macro ALU_DIV_EN:
//   - When defined, op 101 is a full signed divider.
//   - When undefined, op 101 is treated as unsupported: result 0, Z=1, D=1.
module alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] val_A,
    input  logic [31:0] val_B,
    input  logic [2:0]  ALU_op,
    output logic [31:0] ALU_out,
    output logic [31:0] flags
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_DIV = 3'b101;
    localparam logic [2:0] OP_NOT = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    // Signed overflow of a+b: operands agree in sign, result disagrees.
    function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] r);
        add_ovf = (a[31] == b[31]) && (r[31] != a[31]);
    endfunction

    // Signed overflow of a-b: operands differ in sign, result sign differs from a.
    function automatic logic sub_ovf(input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] r);
        sub_ovf = (a[31] != b[31]) && (r[31] != a[31]);
    endfunction

    // Product overflows 32 bits when the upper half is not the sign extension of the lower half.
    function automatic logic mul_ovf(input logic [63:0] p);
        mul_ovf = (p[63:32] != {32{p[31]}});
    endfunction

    logic [31:0] sum_s;
    logic [31:0] diff_s;
    logic [63:0] prod_s;
    logic [31:0] result_s;
    logic        ovf_s;
    logic        dz_s;
    logic [31:0] alu_out_d;
    logic [31:0] alu_out_q;
    logic [31:0] flags_d;
    logic [31:0] flags_q;

    assign sum_s  = val_A + val_B;
    assign diff_s = val_A - val_B;
    // Both operands sign-extended to 64 bits so the full signed product is formed.
    assign prod_s = $signed({{32{val_A[31]}}, val_A}) * $signed({{32{val_B[31]}}, val_B});

    // Operation decode: select the result and its overflow / divide-by-zero status.
    always_comb begin
        result_s = 32'd0;
        ovf_s    = 1'b0;
        dz_s     = 1'b0;
        case (ALU_op)
            OP_ADD: begin
                result_s = sum_s;
                ovf_s    = add_ovf(val_A, val_B, sum_s);
            end
            OP_SUB: begin
                result_s = diff_s;
                ovf_s    = sub_ovf(val_A, val_B, diff_s);
            end
            OP_AND: begin
                result_s = val_A & val_B;
            end
            OP_OR: begin
                result_s = val_A | val_B;
            end
            OP_MUL: begin
                result_s = prod_s[31:0];
                ovf_s    = mul_ovf(prod_s);
            end
            OP_DIV: begin
`ifdef ALU_DIV_EN
                if (val_B == 32'd0) begin
                    result_s = 32'd0;
                    dz_s     = 1'b1;
                end else if ((val_A == 32'h8000_0000) && (val_B == 32'hFFFF_FFFF)) begin
                    // The only quotient that cannot be represented; saturate to the input and flag it.
                    result_s = 32'h8000_0000;
                    ovf_s    = 1'b1;
                end else begin
                    result_s = $unsigned($signed(val_A) / $signed(val_B));
                end
`else
                // No divider is built: report an unsupported op as a zero result with D set.
                result_s = 32'd0;
                dz_s     = 1'b1;
`endif
            end
            OP_NOT: begin
                result_s = ~val_B;
            end
            OP_XOR: begin
                result_s = val_A ^ val_B;
            end
            default: begin
                result_s = 32'd0;
                ovf_s    = 1'b0;
                dz_s     = 1'b0;
            end
        endcase
    end

    // Next-state values for the output registers; flags are rebuilt every cycle.
    always_comb begin
        alu_out_d = result_s;
        flags_d   = {result_s[31], (result_s == 32'd0), dz_s, ovf_s, 28'd0};
    end

    // Output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_out_q <= 32'd0;
            flags_q   <= 32'd0;
        end else begin
            alu_out_q <= alu_out_d;
            flags_q   <= flags_d;
        end
    end

    assign ALU_out = alu_out_q;
    assign flags   = flags_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu -- directed self-checking bench for the alu.
// Expected values are hand-computed. DIV expectations follow the ALU_DIV_EN build setting.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] val_A;
    logic [31:0] val_B;
    logic [2:0]  ALU_op;
    logic [31:0] ALU_out;
    logic [31:0] flags;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    alu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .val_A   (val_A),
        .val_B   (val_B),
        .ALU_op  (ALU_op),
        .ALU_out (ALU_out),
        .flags   (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one op away from the edge, clock it in, then check the registered result and flags.
    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_out,
                       input logic [31:0] exp_flags);
        @(negedge clk);
        ALU_op = op;
        val_A  = a;
        val_B  = b;
        @(posedge clk);
        #1;
        check({tag, "_out"}, ALU_out, exp_out);
        check({tag, "_flags"}, flags, exp_flags);
    endtask

    initial begin
        rst_n  = 1'b0;
        ALU_op = 3'b000;
        val_A  = 32'd3;
        val_B  = 32'd1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", ALU_out, 32'd0);
        check("reset_flags", flags, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("add_3_1",     3'b000, 32'd3,          32'd1,          32'd4,          32'h0000_0000);
        run("add_ovf",     3'b000, 32'h4000_0000,  32'h4000_0000,  32'h8000_0000,  32'h9000_0000);
        run("sub_7_3",     3'b001, 32'd7,          32'd3,          32'd4,          32'h0000_0000);
        run("sub_7_7",     3'b001, 32'd7,          32'd7,          32'd0,          32'h4000_0000);
        run("add_m1_m1",   3'b000, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h8000_0000);
        run("sub_ovf",     3'b001, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  32'h1000_0000);
        run("and_zero",    3'b010, 32'h55,         32'hAA,         32'd0,          32'h4000_0000);
        run("or_ff",       3'b011, 32'h55,         32'hAA,         32'hFF,         32'h0000_0000);
        run("not_3",       3'b110, 32'h1234,       32'd3,          32'hFFFF_FFFC,  32'h8000_0000);
        run("xor",         3'b111, 32'hF0F0,       32'h0FF0,       32'hFF00,       32'h0000_0000);
        run("mul_3_3",     3'b100, 32'd3,          32'd3,          32'd9,          32'h0000_0000);
        run("mul_ovf",     3'b100, 32'h8000_0000,  32'h8000_0000,  32'd0,          32'h5000_0000);
        run("mul_neg",     3'b100, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFA,  32'h8000_0000);
        run("div_4_0",     3'b101, 32'd4,          32'd0,          32'd0,          32'h6000_0000);
        run("after_dz",    3'b000, 32'd3,          32'd1,          32'd4,          32'h0000_0000);
`ifdef ALU_DIV_EN
        run("div_4_2",     3'b101, 32'd4,          32'd2,          32'd2,          32'h0000_0000);
        run("div_m7_2",    3'b101, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'h8000_0000);
        run("div_min_m1",  3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'h9000_0000);
`else
        run("div_4_2",     3'b101, 32'd4,          32'd2,          32'd0,          32'h6000_0000);
        run("div_m7_2",    3'b101, 32'hFFFF_FFF9,  32'd2,          32'd0,          32'h6000_0000);
        run("div_min_m1",  3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h6000_0000);
`endif

        // Reset on an edge with a live op wins; the op appears one edge after release.
        @(negedge clk);
        ALU_op = 3'b000;
        val_A  = 32'd3;
        val_B  = 32'd1;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out", ALU_out, 32'd0);
        check("midrst_flags", flags, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_out", ALU_out, 32'd4);
        check("release_flags", flags, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
